// File: rtl/rtl_sync_fifo.sv
// Single-clock FIFO with registered read data and occupancy-decoded status flags.
// Every one of the 2^FIFO_DEPTH_POWER entries is usable; rejected accesses have no effect.
module rtl_sync_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH_POWER = 8,
  parameter int AFULL_CNT        = 200,
  parameter int AEMPTY_CNT       = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wen,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty_flag,
  output logic                  full_flag,
  output logic                  aempty_flag,
  output logic                  afull_flag
);

  localparam int P = FIFO_DEPTH_POWER;
  localparam int D = 1 << P;
  localparam logic [P-1:0] PTR_ONE   = P'(1);
  localparam logic [P:0]   CNT_ONE   = (P+1)'(1);
  localparam logic [P:0]   DEPTH_CNT = (P+1)'(D);
  localparam logic [P:0]   AFULL_V   = (P+1)'(AFULL_CNT);
  localparam logic [P:0]   AEMPTY_V  = (P+1)'(AEMPTY_CNT);

  logic [DATA_WIDTH-1:0] mem [D];

  logic [P-1:0]          wr_ptr_q, wr_ptr_d;
  logic [P-1:0]          rd_ptr_q, rd_ptr_d;
  logic [P:0]            count_q,  count_d;
  logic [DATA_WIDTH-1:0] dout_q;

  logic wr_ok;
  logic rd_ok;

  // Acceptance uses the flags as they stood before the edge.
  assign wr_ok = wen & ~full_flag;
  assign rd_ok = ren & ~empty_flag;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_ok && !rd_ok)      count_d = count_q + CNT_ONE;
    else if (rd_ok && !wr_ok) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (rd_ok) dout_q <= mem[rd_ptr_q];
    end
  end

  // Storage is left uncleared on reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wr_ptr_q] <= din;
  end

  assign dout        = dout_q;
  assign empty_flag  = (count_q == '0);
  assign full_flag   = (count_q == DEPTH_CNT);
  assign aempty_flag = (count_q <= AEMPTY_V);
  assign afull_flag  = (count_q >= AFULL_V);

endmodule

// File: tb/tb_rtl_sync_fifo.sv
// Randomised and directed bench for rtl_sync_fifo against a queue-based model.
module tb_rtl_sync_fifo;
  localparam int D  = 256;
  localparam int AF = 200;
  localparam int AE = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'd0;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic [7:0] dout;
  logic       empty_flag, full_flag, aempty_flag, afull_flag;

  int checks = 0;
  int errors = 0;

  logic [7:0] dv = 8'd0;
  logic [7:0] mq[$];
  logic [7:0] mdout = 8'd0;

  rtl_sync_fifo #(
    .DATA_WIDTH(8), .FIFO_DEPTH_POWER(8), .AFULL_CNT(AF), .AEMPTY_CNT(AE)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .wen(wen), .ren(ren), .dout(dout),
    .empty_flag(empty_flag), .full_flag(full_flag),
    .aempty_flag(aempty_flag), .afull_flag(afull_flag)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: occupancy is the queue size; a read pops before the write pushes.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mdout = 8'd0;
    end else begin
      automatic bit w_ok = wen && (mq.size() < D);
      automatic bit r_ok = ren && (mq.size() > 0);
      if (r_ok) mdout = mq.pop_front();
      if (w_ok) mq.push_back(din);
    end
    #1;
    chk("dout",   int'(dout),        int'(mdout));
    chk("empty",  int'(empty_flag),  int'(mq.size() == 0));
    chk("full",   int'(full_flag),   int'(mq.size() == D));
    chk("aempty", int'(aempty_flag), int'(mq.size() <= AE));
    chk("afull",  int'(afull_flag),  int'(mq.size() >= AF));
    $display("cyc rst=%0b wen=%0b ren=%0b din=%0d dout=%0d occ=%0d e=%0b f=%0b ae=%0b af=%0b",
             rst, wen, ren, din, dout, mq.size(), empty_flag, full_flag, aempty_flag, afull_flag);
  end

  task automatic cyc(input logic r, input logic w, input logic rd);
    @(negedge clk);
    rst = r; wen = w; ren = rd; din = dv;
    dv = dv + 8'd1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] saved;
    // Reset with both enables high
    repeat (3) cyc(1'b1, 1'b1, 1'b1);
    chk("rst_empty", int'(empty_flag), 1);
    chk("rst_aempty", int'(aempty_flag), 1);
    chk("rst_full", int'(full_flag), 0);
    chk("rst_afull", int'(afull_flag), 0);
    chk("rst_dout", int'(dout), 0);

    // Fill: data 0..255, then ignored writes
    dv = 8'd0;
    for (int i = 1; i <= D; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (i == 1)   chk("wr1_empty", int'(empty_flag), 0);
      if (i == 10)  chk("wr10_aempty", int'(aempty_flag), 1);
      if (i == 11)  chk("wr11_aempty", int'(aempty_flag), 0);
      if (i == 199) chk("wr199_afull", int'(afull_flag), 0);
      if (i == 200) chk("wr200_afull", int'(afull_flag), 1);
      if (i == 255) chk("wr255_full", int'(full_flag), 0);
    end
    chk("wr256_full", int'(full_flag), 1);
    repeat (5) cyc(1'b0, 1'b1, 1'b0);
    chk("overfill_full", int'(full_flag), 1);

    // Drain in order
    for (int i = 0; i < D; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("drain_dout", int'(dout), i);
    end
    chk("drain_empty", int'(empty_flag), 1);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    chk("underrun_dout", int'(dout), 255);

    // Streaming at occupancy 5 across several wraps
    repeat (5) cyc(1'b0, 1'b1, 1'b0);
    repeat (600) cyc(1'b0, 1'b1, 1'b1);
    chk("stream_empty", int'(empty_flag), 0);
    chk("stream_aempty", int'(aempty_flag), 1);
    repeat (5) cyc(1'b0, 1'b0, 1'b1);
    chk("stream_drained", int'(empty_flag), 1);

    // Both enables at empty, then at full
    cyc(1'b0, 1'b1, 1'b1);
    chk("both_at_empty", int'(empty_flag), 0);
    repeat (D - 1) cyc(1'b0, 1'b1, 1'b0);
    chk("refill_full", int'(full_flag), 1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("both_at_full", int'(full_flag), 0);

    // Mid-operation reset at occupancy 100
    repeat (D - 1 - 100) cyc(1'b0, 1'b0, 1'b1);
    chk("occ100_afull", int'(afull_flag), 0);
    chk("occ100_aempty", int'(aempty_flag), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("mrst_empty", int'(empty_flag), 1);
    chk("mrst_aempty", int'(aempty_flag), 1);
    chk("mrst_afull", int'(afull_flag), 0);
    chk("mrst_dout", int'(dout), 0);
    saved = dv;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("post_rst_data", int'(dout), int'(saved));

    // Random traffic with varying bias and occasional reset
    for (int i = 0; i < 3000; i++) begin
      automatic int phase = (i / 300) % 3;
      automatic logic w = (phase == 0) ? ($urandom_range(9, 0) < 8) :
                          (phase == 1) ? ($urandom_range(9, 0) < 2) : 1'($urandom);
      automatic logic r = (phase == 0) ? ($urandom_range(9, 0) < 2) :
                          (phase == 1) ? ($urandom_range(9, 0) < 8) : 1'($urandom);
      automatic logic rr = ($urandom_range(499, 0) == 0);
      cyc(rr, w, r);
    end

    cyc(1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
